// File: rtl/frame_parser.sv
// Byte-stuffed frame parser: FLAG f0 SEP f1 ... SEP f(N-1) FLAG into N right-aligned field
// registers, with escape decoding, per-frame error pulses and a valid/ready output with overrun.
module frame_parser #(
  parameter int unsigned FIELD_NUM   = 2,
  parameter int unsigned FIELD_BYTES = 4,
  parameter logic [7:0]  FLAG        = 8'h7E,
  parameter logic [7:0]  SEP         = 8'h7F,
  parameter logic [7:0]  ESC         = 8'h7D,
  parameter logic [7:0]  ESC_XOR     = 8'h20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         in_data,
  input  logic                               in_valid,
  output logic [FIELD_NUM*FIELD_BYTES*8-1:0] out_fields,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               err,
  output logic [1:0]                         err_code,
  output logic                               overrun,
  output logic                               busy
);

  localparam int unsigned FW = 8 * FIELD_BYTES;
  localparam int unsigned IW = (FIELD_NUM > 1) ? $clog2(FIELD_NUM) : 1;
  localparam int unsigned CW = $clog2(FIELD_BYTES + 1);

  localparam logic [1:0] E_OVF = 2'd1;
  localparam logic [1:0] E_CNT = 2'd2;
  localparam logic [1:0] E_ESC = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_ESC} state_t;

  state_t          r_state, w_state_nxt;
  logic [FW-1:0]   r_work [FIELD_NUM];
  logic [FW-1:0]   w_work_nxt [FIELD_NUM];
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_any, w_any_nxt;
  logic            w_err, w_good, w_store, w_clear;
  logic [1:0]      w_code;
  logic [7:0]      w_byte;

  logic [FIELD_NUM*FW-1:0] r_out;
  logic                    r_valid, r_err, r_overrun;
  logic [1:0]              r_err_code;

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_any_nxt   = r_any;
    w_err       = 1'b0;
    w_code      = '0;
    w_good      = 1'b0;
    w_store     = 1'b0;
    w_clear     = 1'b0;
    w_byte      = in_data;

    if (in_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (in_data == FLAG) begin
            w_clear     = 1'b1;
            w_state_nxt = S_RECV;
          end
        end
        S_RECV: begin
          if (in_data == FLAG) begin
            // Closing flag doubles as the next opening flag, so working state always restarts.
            w_clear = 1'b1;
            if (r_any) begin
              if (r_idx == IW'(FIELD_NUM - 1)) begin
                w_good = 1'b1;
              end else begin
                w_err  = 1'b1;
                w_code = E_CNT;
              end
            end
          end else if (in_data == SEP) begin
            if (r_idx == IW'(FIELD_NUM - 1)) begin
              w_err       = 1'b1;
              w_code      = E_CNT;
              w_state_nxt = S_IDLE;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
              w_cnt_nxt = '0;
              w_any_nxt = 1'b1;
            end
          end else if (in_data == ESC) begin
            w_state_nxt = S_ESC;
          end else begin
            w_store = 1'b1;
          end
        end
        S_ESC: begin
          if (in_data == FLAG) begin
            w_err       = 1'b1;
            w_code      = E_ESC;
            w_clear     = 1'b1;
            w_state_nxt = S_RECV;
          end else if (in_data == ESC) begin
            w_err       = 1'b1;
            w_code      = E_ESC;
            w_state_nxt = S_IDLE;
          end else begin
            w_byte      = in_data ^ ESC_XOR;
            w_store     = 1'b1;
            w_state_nxt = S_RECV;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    if (w_clear) begin
      w_work_nxt = '{default: '0};
      w_idx_nxt  = '0;
      w_cnt_nxt  = '0;
      w_any_nxt  = 1'b0;
    end

    if (w_store) begin
      if (r_cnt == CW'(FIELD_BYTES)) begin
        w_err       = 1'b1;
        w_code      = E_OVF;
        w_state_nxt = S_IDLE;
      end else begin
        w_work_nxt[r_idx] = (r_work[r_idx] << 8) | FW'(w_byte);
        w_cnt_nxt         = r_cnt + 1'b1;
        w_any_nxt         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_work     <= '{default: '0};
      r_idx      <= '0;
      r_cnt      <= '0;
      r_any      <= 1'b0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_work     <= w_work_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_any      <= w_any_nxt;
      r_err      <= w_err;
      r_err_code <= w_code;
      r_overrun  <= w_good && r_valid && !out_ready;
      if (w_good) begin
        for (int unsigned k = 0; k < FIELD_NUM; k++) begin
          r_out[k*FW +: FW] <= r_work[k];
        end
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_fields = r_out;
  assign out_valid  = r_valid;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_frame_parser.sv
// Directed bench for frame_parser: expected frames and error codes are queued as bytes are
// driven and matched against DUT output by a negedge monitor.
module tb_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [63:0] out_fields;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic [1:0]  err_code;
  logic        overrun;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_ovr    = 0;

  logic [63:0] exp_frames[$];
  logic [1:0]  exp_errs[$];

  frame_parser #(
    .FIELD_NUM(2),
    .FIELD_BYTES(4),
    .FLAG(8'h7E),
    .SEP(8'h7F),
    .ESC(8'h7D),
    .ESC_XOR(8'h20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_fields(out_fields),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err(err),
    .err_code(err_code),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: accepted frames and error pulses must match the queued expectations in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_frames.size() == 0) check("unexpected_frame", out_fields, 64'hx);
        else check("frame", out_fields, exp_frames.pop_front());
      end
      if (err) begin
        if (exp_errs.size() == 0) check("unexpected_err", {62'd0, err_code}, 64'hx);
        else check("err_code", {62'd0, err_code}, {62'd0, exp_errs.pop_front()});
      end
      if (overrun) n_ovr++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_fields", out_fields, 64'd0);
    check("rst_err", {61'd0, err, err_code}, 64'd0);
    check("rst_overrun", {63'd0, overrun}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    idle(1);

    // 1: basic frame
    exp_frames.push_back({32'h00000005, 32'h0000012C});
    put(8'h7E); put(8'h00); put(8'h00); put(8'h01); put(8'h2C); put(8'h7F);
    put(8'h00); put(8'h00); put(8'h00); put(8'h05);
    check("t1_not_yet_valid", {63'd0, out_valid}, 64'd0);
    put(8'h7E);
    check("t1_valid_latency", {63'd0, out_valid}, 64'd1);
    check("t1_fields", out_fields, {32'h00000005, 32'h0000012C});
    idle(2);
    check("t1_valid_cleared", {63'd0, out_valid}, 64'd0);

    // 2: escape decoding with idle cycles inside an escape
    exp_frames.push_back({32'h00007D7F, 32'h0000007E});
    put(8'h7E); put(8'h7D);
    idle(3);
    check("t2_busy_in_esc", {63'd0, busy}, 64'd1);
    put(8'h5E); put(8'h7F); put(8'h7D); put(8'h5D); put(8'h7D); put(8'h5F); put(8'h7E);
    check("t2_fields", out_fields, {32'h00007D7F, 32'h0000007E});
    idle(2);

    // 3: overflow then recovery (DUT sits in RECV after previous closing flag)
    put(8'h7E); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    exp_errs.push_back(2'd1);
    put(8'h05);
    check("t3_err_pulse", {61'd0, err, err_code}, {61'd0, 1'b1, 2'd1});
    check("t3_idle_after_ovf", {63'd0, busy}, 64'd0);
    exp_frames.push_back({32'h0000000B, 32'h0000000A});
    put(8'h7E); put(8'h0A); put(8'h7F); put(8'h0B); put(8'h7E);
    check("t3_fields", out_fields, {32'h0000000B, 32'h0000000A});
    idle(2);

    // 4: field count errors and empty frames
    put(8'h7E); put(8'h01);
    exp_errs.push_back(2'd2);
    put(8'h7E);
    put(8'h7E); put(8'h01); put(8'h7F); put(8'h02);
    exp_errs.push_back(2'd2);
    put(8'h7F);
    check("t4_err_pulse", {61'd0, err, err_code}, {61'd0, 1'b1, 2'd2});
    put(8'h7E); put(8'h7E); put(8'h7E);
    idle(1);
    check("t4_empty_no_valid", {63'd0, out_valid}, 64'd0);

    // 5a: bad escape; the aborting flag opens the next frame
    put(8'h01); put(8'h7D);
    exp_errs.push_back(2'd3);
    put(8'h7E);
    check("t5_err_esc", {61'd0, err, err_code}, {61'd0, 1'b1, 2'd3});
    exp_frames.push_back({32'h00000003, 32'h00000002});
    put(8'h02); put(8'h7F); put(8'h03); put(8'h7E);
    idle(2);

    // 5b: ESC ESC aborts to IDLE
    put(8'h7E); put(8'h7D);
    exp_errs.push_back(2'd3);
    put(8'h7D);
    check("t5_esc_esc_idle", {63'd0, busy}, 64'd0);

    // 5c: backpressure and overrun
    out_ready = 1'b0;
    put(8'h7E); put(8'h11); put(8'h7F); put(8'h22); put(8'h7E);
    check("t5_first_valid", {63'd0, out_valid}, 64'd1);
    check("t5_first_no_ovr", {63'd0, overrun}, 64'd0);
    put(8'h33); put(8'h7F); put(8'h44); put(8'h7E);
    check("t5_overrun", {63'd0, overrun}, 64'd1);
    check("t5_overwrite", out_fields, {32'h00000044, 32'h00000033});
    idle(1);
    check("t5_overrun_pulse", {63'd0, overrun}, 64'd0);
    check("t5_still_valid", {63'd0, out_valid}, 64'd1);
    exp_frames.push_back({32'h00000044, 32'h00000033});
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("t5_accepted", {63'd0, out_valid}, 64'd0);
    check("t5_fields_held", out_fields, {32'h00000044, 32'h00000033});
    out_ready = 1'b1;

    // 6: reset mid-frame
    put(8'h7E); put(8'h01); put(8'h7F);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    put(8'h02); put(8'h7E);
    idle(1);
    check("t6_no_valid", {63'd0, out_valid}, 64'd0);
    exp_frames.push_back({32'h00000004, 32'h00000003});
    put(8'h7E); put(8'h03); put(8'h7F); put(8'h04); put(8'h7E);
    check("t6_fields", out_fields, {32'h00000004, 32'h00000003});
    idle(3);

    check("frames_left", 64'(exp_frames.size()), 64'd0);
    check("errs_left", 64'(exp_errs.size()), 64'd0);
    check("overrun_count", 64'(n_ovr), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
